// File: rtl/riscv_pkg.sv
// Shared RISC-V front-end types: word width, NOP encoding and the fetch
// response record that IF/ID also consumes.
package riscv_pkg;

   localparam int XLEN = 32;
   localparam logic [XLEN-1:0] NOP = 32'h00000013;

   typedef struct packed {
      logic [XLEN-1:0] instr;
      logic [XLEN-1:0] addr;
      logic            fault;
   } rsp_t;

   localparam int RSP_W = $bits(rsp_t);

   // A fetch faults when the PC is not word aligned or points past the RAM.
   function automatic logic fetch_fault(input logic [XLEN-1:0] addr,
                                        input logic [XLEN:0]   limit);
      return (addr[1:0] != 2'b00) || ({1'b0, addr} >= limit);
   endfunction

endpackage

// File: rtl/imem_responder_if.sv
// Fetch request / response channels between the fetch stage (master) and
// the instruction-memory responder (slave).
interface imem_responder_if;
   import riscv_pkg::*;

   logic            req_valid;
   logic            req_ready;
   logic [XLEN-1:0] req_addr;
   logic            flush;
   logic            rsp_valid;
   logic            rsp_ready;
   logic [XLEN-1:0] rsp_instr;
   logic [XLEN-1:0] rsp_addr;
   logic            rsp_fault;

   modport master (
      output req_valid, req_addr, flush, rsp_ready,
      input  req_ready, rsp_valid, rsp_instr, rsp_addr, rsp_fault
   );

   modport slave (
      input  req_valid, req_addr, flush, rsp_ready,
      output req_ready, rsp_valid, rsp_instr, rsp_addr, rsp_fault
   );

endinterface

// File: rtl/resp_fifo.sv
// Small synchronous FIFO of fetch responses; clear empties it but keeps a
// push arriving in the same cycle.
module resp_fifo
   import riscv_pkg::*;
#(
   parameter int DEPTH = 3,
   parameter int CW    = $clog2(DEPTH + 1)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          push,
   input  logic          pop,
   input  logic          clear,
   input  rsp_t          wdata,
   output rsp_t          rdata,
   output logic          full,
   output logic          empty,
   output logic [CW-1:0] count
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   rsp_t          mem [DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic          do_pop;

   function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   assign empty  = (count == '0);
   assign full   = (count == CW'(DEPTH));
   assign do_pop = pop && !empty;
   assign rdata  = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (clear) begin
         rd_ptr <= '0;
         wr_ptr <= push ? PW'(1) : '0;
         count  <= push ? CW'(1) : '0;
      end else begin
         if (push)
            wr_ptr <= bump(wr_ptr);
         if (do_pop)
            rd_ptr <= bump(rd_ptr);
         count <= count + CW'(push) - CW'(do_pop);
      end
   end

   always_ff @(posedge clk) begin
      if (push)
         mem[clear ? '0 : wr_ptr] <= wdata;
   end

endmodule

// File: rtl/imem_responder.sv
// Instruction-memory responder: reads the instruction RAM for each fetch PC
// and returns the words in order after a fixed latency, honouring flushes.
module imem_responder
   import riscv_pkg::*;
#(
   parameter int    LATENCY     = 2,
   parameter int    DEPTH_WORDS = 1024,
   parameter string INIT_FILE   = ""
) (
   input  logic            clk,
   input  logic            rst,
   imem_responder_if.slave bus
);

   localparam int AW = $clog2(DEPTH_WORDS);
   localparam int CW = $clog2(LATENCY + 2);
   localparam logic [XLEN:0] BYTE_LIMIT = (XLEN + 1)'(4 * DEPTH_WORDS);

   logic [XLEN-1:0] mem [DEPTH_WORDS] = '{default: NOP};

   logic          accept;
   logic          req_fault;
   logic [AW-1:0] idx;
   logic          push;
   logic          pop;
   logic          full;
   logic          empty;
   logic [3:0]    stage_count;
   logic [3:0]    outstanding;
   logic [CW-1:0] fifo_count;
   rsp_t          push_data;
   rsp_t          head;

   assign accept    = bus.req_valid && bus.req_ready;
   assign idx       = bus.req_addr[AW+1:2];
   assign req_fault = fetch_fault(bus.req_addr, BYTE_LIMIT);

   // The final latency step is the FIFO write itself, so only LATENCY-1
   // explicit stage registers sit in front of it.
   generate
      if (LATENCY == 1) begin : g_direct
         assign push        = accept;
         assign push_data   = '{instr: req_fault ? NOP : mem[idx],
                                addr:  bus.req_addr,
                                fault: req_fault};
         assign stage_count = '0;
      end else begin : g_stages
         logic [LATENCY-2:0] st_valid;
         rsp_t               st_data [LATENCY-1];

         always_ff @(posedge clk) begin
            if (rst) begin
               st_valid <= '0;
            end else begin
               st_valid[0] <= accept;
               for (int i = 1; i < LATENCY - 1; i++)
                  st_valid[i] <= st_valid[i-1] && !bus.flush;
            end
         end

         always_ff @(posedge clk) begin
            if (accept)
               st_data[0] <= '{instr: mem[idx], addr: bus.req_addr, fault: req_fault};
            for (int i = 1; i < LATENCY - 1; i++)
               st_data[i] <= st_data[i-1];
         end

         assign push        = st_valid[LATENCY-2] && !bus.flush;
         assign push_data   = '{instr: st_data[LATENCY-2].fault ? NOP : st_data[LATENCY-2].instr,
                                addr:  st_data[LATENCY-2].addr,
                                fault: st_data[LATENCY-2].fault};
         assign stage_count = 4'($countones(st_valid));
      end
   endgenerate

   assign pop = bus.rsp_valid && bus.rsp_ready;

   resp_fifo #(.DEPTH(LATENCY + 1)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .pop   (pop),
      .clear (bus.flush),
      .wdata (push_data),
      .rdata (head),
      .full  (full),
      .empty (empty),
      .count (fifo_count)
   );

   // Admission is capped by everything still owed downstream, which is what
   // guarantees the FIFO never has to absorb a push while full.
   assign outstanding   = stage_count + 4'(fifo_count);
   assign bus.req_ready = (outstanding < 4'(LATENCY + 1));

   assign bus.rsp_valid = !empty;
   assign bus.rsp_instr = empty ? NOP : head.instr;
   assign bus.rsp_addr  = empty ? '0 : head.addr;
   assign bus.rsp_fault = empty ? 1'b0 : head.fault;

   assert property (@(posedge clk) disable iff (rst) !(push && full && !bus.flush));

endmodule

// File: tb/tb_imem_responder.sv
// Randomised bench for imem_responder: a queue of owed responses, each with
// its due cycle, predicts ready/valid and the response fields every cycle.
module tb_imem_responder;
   import riscv_pkg::*;

   localparam int LATENCY     = 2;
   localparam int DEPTH_WORDS = 1024;

   logic clk = 1'b0;
   logic rst = 1'b1;

   imem_responder_if bus();

   imem_responder #(
      .LATENCY     (LATENCY),
      .DEPTH_WORDS (DEPTH_WORDS)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] instr;
      logic        fault;
      int          due;
   } exp_t;

   exp_t        pend[$];
   logic [31:0] ram_model [DEPTH_WORDS];
   int          cycle      = 0;
   int          test_count = 0;
   int          fail_count = 0;

   task automatic checkOutput(input string tag, input logic [31:0] actual,
                              input logic [31:0] expected);
      test_count++;
      if (actual !== expected) begin
         fail_count++;
         $display("[TB] FAIL %s (cycle %0d): got %h, expected %h", tag, cycle, actual, expected);
      end
   endtask

   function automatic exp_t make_expected(input logic [31:0] a);
      exp_t e;
      e.addr  = a;
      e.fault = (a[1:0] != 2'b00) || (a >= 32'(4 * DEPTH_WORDS));
      e.instr = e.fault ? NOP : ram_model[int'(a >> 2)];
      e.due   = cycle + LATENCY;
      return e;
   endfunction

   // One cycle: check what the DUT shows now, drive this cycle's inputs,
   // then advance the model by the handshakes it predicts.
   task automatic applyStimulus(input logic v, input logic [31:0] a, input logic f,
                                input logic rr, input logic r);
      logic exp_ready;
      logic exp_valid;
      exp_ready = (pend.size() < LATENCY + 1);
      exp_valid = 1'b0;
      if (pend.size() > 0)
         exp_valid = (pend[0].due <= cycle);
      checkOutput("req_ready", 32'(bus.req_ready), 32'(exp_ready));
      checkOutput("rsp_valid", 32'(bus.rsp_valid), 32'(exp_valid));
      if (exp_valid) begin
         checkOutput("rsp_instr", bus.rsp_instr, pend[0].instr);
         checkOutput("rsp_addr", bus.rsp_addr, pend[0].addr);
         checkOutput("rsp_fault", 32'(bus.rsp_fault), 32'(pend[0].fault));
      end
      rst           = r;
      bus.req_valid = v;
      bus.req_addr  = a;
      bus.flush     = f;
      bus.rsp_ready = rr;
      if (r) begin
         pend.delete();
      end else begin
         if (exp_valid && rr)
            void'(pend.pop_front());
         if (f)
            pend.delete();
         if (v && exp_ready)
            pend.push_back(make_expected(a));
      end
      @(negedge clk);
      cycle++;
   endtask

   task automatic idle(input int n, input logic rr);
      for (int k = 0; k < n; k++)
         applyStimulus(1'b0, 32'h0, 1'b0, rr, 1'b0);
   endtask

   function automatic logic [31:0] random_addr();
      int sel;
      sel = $urandom_range(0, 15);
      if (sel < 12)
         return {22'b0, 8'($urandom_range(0, 63)), 2'b00};
      else if (sel < 14)
         return {24'b0, 6'($urandom_range(0, 63)), 2'($urandom_range(1, 3))};
      else if (sel == 14)
         return $urandom() | 32'h0000_1000;
      else
         return ($urandom_range(0, 1) == 0) ? 32'h0000_0FFC : 32'h0000_1000;
   endfunction

   initial begin
      bus.req_valid = 1'b0;
      bus.req_addr  = '0;
      bus.flush     = 1'b0;
      bus.rsp_ready = 1'b0;

      for (int i = 0; i < DEPTH_WORDS; i++)
         ram_model[i] = NOP;
      for (int i = 0; i < 64; i++)
         ram_model[i] = $urandom();
      ram_model[DEPTH_WORDS-1] = $urandom();
      ram_model[0] = 32'h00500093;
      ram_model[1] = 32'h00A00113;
      ram_model[2] = 32'h002081B3;
      ram_model[3] = 32'h00000013;

      #1;
      for (int i = 0; i < 64; i++)
         dut.mem[i] = ram_model[i];
      dut.mem[DEPTH_WORDS-1] = ram_model[DEPTH_WORDS-1];

      repeat (2) @(negedge clk);
      checkOutput("reset_instr", bus.rsp_instr, NOP);
      checkOutput("reset_addr", bus.rsp_addr, 32'h0);
      checkOutput("reset_fault", 32'(bus.rsp_fault), 32'h0);

      // streaming four words back to back
      for (int k = 0; k < 4; k++)
         applyStimulus(1'b1, 32'(4 * k), 1'b0, 1'b1, 1'b0);
      idle(3, 1'b1);

      // back-pressure: only LATENCY+1 requests fit while the sink stalls
      for (int k = 0; k < 5; k++)
         applyStimulus(1'b1, 32'h20 + 32'(4 * k), 1'b0, 1'b0, 1'b0);
      idle(5, 1'b1);

      // flush with redirect in the same cycle
      applyStimulus(1'b1, 32'h10, 1'b0, 1'b1, 1'b0);
      applyStimulus(1'b1, 32'h14, 1'b0, 1'b1, 1'b0);
      applyStimulus(1'b1, 32'h40, 1'b1, 1'b1, 1'b0);
      idle(4, 1'b1);

      // faults and the last valid word
      applyStimulus(1'b1, 32'h6, 1'b0, 1'b1, 1'b0);
      applyStimulus(1'b1, 32'h1000, 1'b0, 1'b1, 1'b0);
      applyStimulus(1'b1, 32'h8, 1'b0, 1'b1, 1'b0);
      applyStimulus(1'b1, 32'hFFC, 1'b0, 1'b1, 1'b0);
      idle(4, 1'b1);

      // reset with work in flight and queued
      for (int k = 0; k < 3; k++)
         applyStimulus(1'b1, 32'(4 * k), 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b1, 32'h30, 1'b0, 1'b0, 1'b1);
      applyStimulus(1'b1, 32'h0, 1'b0, 1'b1, 1'b0);
      idle(3, 1'b1);

      // flush while the head is stalled
      applyStimulus(1'b1, 32'h10, 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b1, 32'h14, 1'b0, 1'b0, 1'b0);
      idle(2, 1'b0);
      applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
      idle(3, 1'b1);

      for (int k = 0; k < 3000; k++)
         applyStimulus(1'($urandom_range(0, 3) != 0), random_addr(),
                       1'($urandom_range(0, 19) == 0),
                       1'($urandom_range(0, 9) < 7),
                       1'($urandom_range(0, 99) == 0));
      idle(6, 1'b1);

      $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
      $finish;
   end

endmodule
